// File: rtl/dvp_tx.sv
// dvp_tx: DVP byte-serial video transmitter (RGB565 as two bytes per pixel, pclk = clk/2).
// Optional DVP_TX_TEST_PATTERN_EN adds test_mode to replace pix_data with 8 colour bars.
module dvp_tx #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 16,
  parameter int V_PORCH  = 4,
  parameter int V_FRONT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        pix_ready,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        underrun,
  output logic        busy
);
  localparam int LL = 2*H_ACTIVE + H_BLANK;
  localparam int LINES = V_PORCH + V_ACTIVE + V_FRONT;
  localparam int CW = $clog2(LL);
  localparam int LW = $clog2(LINES);
  typedef enum logic [2:0] {IDLE, PORCH, ACTIVE, HBLANK, FRONT} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [7:0] lo;
  logic [15:0] pix;
  logic take, tm, hi, col_end;
  assign col_end = col == CW'(LL-1);
  // hi marks the falling-pclk edge that launches a pixel's high byte
  assign hi = pclk && ((state == PORCH && col_end && line == LW'(V_PORCH-1)) ||
                       (state == ACTIVE && col[0] && col != CW'(2*H_ACTIVE-1)) ||
                       (state == HBLANK && col_end && line != LW'(V_PORCH+V_ACTIVE-1)));
`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int BW = H_ACTIVE/8 > 0 ? H_ACTIVE/8 : 1;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [CW-1:0] ncol;
  logic [31:0] bi;
  logic [2:0] bar;
  assign ncol = state == ACTIVE ? col + 1'b1 : '0;
  assign bi = (32'(ncol) >> 1) / BW;
  assign bar = bi > 7 ? 3'd7 : bi[2:0];
  assign tm = test_mode;
  assign pix = tm ? BARS[bar] : pix_valid ? pix_data : '0;
  assign take = !tm && pix_valid;
`else
  assign tm = 1'b0;
  assign pix = pix_valid ? pix_data : '0;
  assign take = pix_valid;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      line <= '0;
      lo <= '0;
      pclk <= 1'b0;
      vsync <= 1'b0;
      href <= 1'b0;
      data <= '0;
      pix_ready <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      pclk <= ~pclk;
      frame_done <= 1'b0;
      pix_ready <= hi && take;
      if (hi && !take && !tm) underrun <= 1'b1;
      if (hi) begin
        data <= pix[15:8];
        lo <= pix[7:0];
        href <= 1'b1;
      end
      if (pclk) begin
        case (state)
          IDLE: if (en) begin
            state <= PORCH;
            vsync <= 1'b1;
            busy <= 1'b1;
          end
          PORCH: begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) line <= line + 1'b1;
            if (col_end && line == LW'(V_PORCH-1)) state <= ACTIVE;
          end
          ACTIVE: begin
            col <= col + 1'b1;
            if (col == CW'(2*H_ACTIVE-1)) begin
              state <= HBLANK;
              href <= 1'b0;
              data <= '0;
            end else if (!col[0]) data <= lo;
          end
          HBLANK: begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) line <= line + 1'b1;
            if (col_end && line == LW'(V_PORCH+V_ACTIVE-1)) begin
              state <= FRONT;
              vsync <= 1'b0;
              frame_done <= 1'b1;
            end else if (col_end) state <= ACTIVE;
          end
          FRONT: begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) line <= line == LW'(LINES-1) ? '0 : line + 1'b1;
            if (col_end && line == LW'(LINES-1)) begin
              state <= en ? PORCH : IDLE;
              vsync <= en;
              busy <= en;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: randomized self-checking bench for dvp_tx against a per-pclk-period frame model.
module tb_dvp_tx;
`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int HA = 8;
`else
  localparam int HA = 4;
`endif
  localparam int VA = 2, HB = 2, VP = 1, VF = 1;
  localparam int LL = 2*HA + HB;
  localparam int N = (VP + VA + VF) * LL;
  localparam int BW = HA/8 > 0 ? HA/8 : 1;
  logic clk = 0, rst = 1, en = 0, pix_valid = 0;
  logic [15:0] pix_data = 0;
  logic pix_ready, pclk, vsync, href, frame_done, underrun, busy;
  logic [7:0] data;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [15:0] dq [2*N];
  logic vq [2*N];
  logic ur_exp = 0;
  int tests = 0, fails = 0, rdy, fd;
`ifdef DVP_TX_TEST_PATTERN_EN
  logic tm = 0;
`endif

  dvp_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_PORCH(VP), .V_FRONT(VF)) dut (
    .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
`ifdef DVP_TX_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .pix_ready(pix_ready), .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .underrun(underrun), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pclk"}, pclk, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_href"}, href, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // t counts clk from the first negedge with vsync high; period p = t/2
  task automatic run_frame(input bit rnd, input int drop_t, input bit keep_en, input bit tmode,
                           output int nrdy, output int nfd);
    int p, ph, ln, c;
    logic [15:0] cur, exp_d;
    bit act, v, r;
    nrdy = 0; nfd = 0; cur = 0;
    @(negedge clk);
    for (int n = 0; n < 400 && !vsync; n++) @(negedge clk);
    chk("vs_start", vsync, 1);
    for (int t = 0; t < 2*N; t++) begin
      if (t > 0) @(negedge clk);
      p = t/2; ph = t%2; ln = p/LL; c = p%LL;
      act = ln >= VP && ln < VP+VA && c < 2*HA;
      r = 0; exp_d = 0;
      if (act && c%2 == 0) begin
        if (ph == 0) begin
          v = vq[t-1];
          cur = tmode ? bars[(c/2)/BW] : v ? dq[t-1] : 16'h0000;
          r = !tmode && v;
          if (!tmode && !v) ur_exp = 1;
        end
        exp_d = {8'h00, cur[15:8]};
      end else if (act) exp_d = {8'h00, cur[7:0]};
      chk("pclk", pclk, 16'(ph));
      chk("vsync", vsync, ln < VP+VA);
      chk("href", href, act);
      chk("data", data, exp_d);
      chk("pix_ready", pix_ready, r);
      chk("frame_done", frame_done, ph == 0 && p == (VP+VA)*LL);
      chk("busy", busy, 1);
      chk("underrun", underrun, ur_exp);
      nrdy += pix_ready;
      nfd += frame_done;
      en = keep_en;
      pix_valid = (t == drop_t) ? 1'b0 : rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      pix_data = rnd ? 16'($urandom) : 16'h1234;
      dq[t] = pix_data;
      vq[t] = pix_valid;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0; en = 1; pix_valid = 1; pix_data = 16'h1234;
    run_frame(0, -1, 1, 0, rdy, fd);
    chk("rdy_count", 16'(rdy), HA*VA);
    chk("fd_count", 16'(fd), 1);
    run_frame(0, (VP*LL + 4)*2 - 1, 1, 0, rdy, fd);
    chk("rdy_count_drop", 16'(rdy), HA*VA - 1);
    run_frame(1, -1, 1, 0, rdy, fd);
    chk("fd_count_rnd", 16'(fd), 1);
    run_frame(0, -1, 0, 0, rdy, fd);
    chk("fd_count_last", 16'(fd), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_vsync", vsync, 0);
    end
    rst = 1;
    @(negedge clk);
    ur_exp = 0;
    chk_zero("rst_idle");
    rst = 0; en = 1; pix_valid = 1;
    for (int n = 0; n < 400 && !href; n++) @(negedge clk);
    chk("href_seen", href, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_zero("rst_active");
    rst = 0; en = 0;
    for (int i = 0; i < 2*N; i++) begin
      @(negedge clk);
      chk("abort_fdone", frame_done, 0);
      chk("abort_vsync", vsync, 0);
    end
`ifdef DVP_TX_TEST_PATTERN_EN
    tm = 1; en = 1;
    run_frame(1, -1, 0, 1, rdy, fd);
    chk("tm_rdy_count", 16'(rdy), 0);
    chk("tm_fd_count", 16'(fd), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dvp_tx.md
DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16, pclk periods with href low after each active line.
REQ-004 SHALL have parameter V_PORCH, default 4, lines with vsync high and href low before the first active line.
REQ-005 SHALL have parameter V_FRONT, default 4, lines with vsync low after the last active line.
REQ-006 SHALL have ports, clock and reset first:
 clk  in  1  system clock
 rst  in  1  reset, synchronous, active-high
 en  in  1  start/continue frames
 pix_data  in  16  RGB565 pixel
 pix_valid  in  1  pix_data is valid
 pix_ready  out  1  pixel consumed this clk
 pclk  out  1  pixel clock, clk/2
 vsync  out  1  high for the whole frame (porch plus active)
 href  out  1  high during active bytes
 data  out  8  byte bus
 frame_done  out  1  one-clk pulse when vsync falls
 underrun  out  1  sticky: pixel needed while pix_valid low
 busy  out  1  frame in progress

Function
REQ-007 SHALL toggle pclk on every clk edge, free-running from reset.
REQ-008 SHALL update vsync, href and data only on the clk edge where pclk goes 1->0, so they are stable at each rising pclk.
REQ-009 SHALL implement states IDLE, PORCH, ACTIVE, HBLANK and FRONT.
REQ-010 IDLE: vsync=0, href=0, data=0, busy=0; on a pclk falling edge with en=1, go to PORCH with vsync=1 and busy=1.
REQ-011 PORCH: V_PORCH lines of (2*H_ACTIVE+H_BLANK) pclk periods each, with href=0; then go to ACTIVE.
REQ-012 ACTIVE: href=1 for 2*H_ACTIVE pclk periods, sending high byte pix_data[15:8] then low byte pix_data[7:0] per pixel; then go to HBLANK.
REQ-013 HBLANK: href=0, data=0 for H_BLANK periods; after line V_ACTIVE-1, go to FRONT, else back to ACTIVE.
REQ-014 FRONT: vsync=0 for V_FRONT lines; frame_done pulses for one clk on the edge where vsync drops; at the end of FRONT, go to PORCH if en=1, else IDLE.
REQ-015 Pixel consumption: pix_ready SHALL pulse for one clk on the edge that outputs a high byte, and only if pix_valid=1; the low byte SHALL come from the same latched pixel.
REQ-016 Underrun: if pix_valid=0 when a high byte is due, the block SHALL send 0x0000 for that pixel, keep pix_ready=0 and set underrun; underrun SHALL clear only on rst.
REQ-017 Deasserting en mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-018 Column counter width SHALL be clog2(2*H_ACTIVE+H_BLANK) and line counter width clog2(V_PORCH+V_ACTIVE+V_FRONT); both wrap to 0 at each line or frame boundary.

Reset
REQ-019 On rst: pclk=0, vsync=0, href=0, data=0x00, pix_ready=0, frame_done=0, underrun=0, busy=0; state=IDLE; counters=0.
REQ-020 rst mid-frame SHALL abort immediately to IDLE with no frame_done pulse.

Configuration
REQ-021 With DVP_TX_TEST_PATTERN_EN defined, an extra input test_mode (1 bit) SHALL be present; when it is 1, pixels SHALL come from internal 8-bar colour bars instead of pix_data.
REQ-022 Bar colours in order SHALL be FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, with bar width H_ACTIVE/8 pixels.
REQ-023 In test mode, pix_ready SHALL stay 0 and underrun SHALL NOT be set.
REQ-024 Without DVP_TX_TEST_PATTERN_EN, there is no test_mode port and no pattern logic.

Verification
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_PORCH=1, V_FRONT=1.
REQ-025 rst, then en=1, pix_valid=1, pix_data=0x1234 constant -> each active line shows 8 bytes 12,34,12,34,... with href high for 8 pclk periods, then low for 2.
REQ-026 Same stimulus -> vsync high for exactly 3 lines (30 pclk periods, 60 clk), frame_done pulses once, and pix_ready pulses 8 times per frame.
REQ-027 pix_valid=0 during the 3rd pixel of line 0 -> bytes 00,00 in that slot, underrun=1 until rst.
REQ-028 en pulsed high then dropped during PORCH -> one full frame, then IDLE with busy=0.
REQ-029 rst asserted during ACTIVE -> next clk all outputs at reset values and no frame_done pulse.
REQ-030 With DVP_TX_TEST_PATTERN_EN defined and test_mode=1, H_ACTIVE=8 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 with pix_ready=0.
